camlink_frame_source: RTL
=========================

CAMLINK_FRAME_SOURCE -- requirements
Module: camlink_frame_source

Interface
REQ-001 SHALL have parameter WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 512, lines per frame.
REQ-003 SHALL have parameter BPP, default 12, grayscale bits per pixel.
REQ-004 SHALL have parameter COLORED, default 0; 1 selects 24-bit RGB.
REQ-005 SHALL have parameter DATA_WIDTH, default COLORED ? 24 : BPP, pixel bus width.
REQ-006 SHALL have parameter FV_TO_LV, default 4, cycles fval high before first lval (minimum 1).
REQ-007 SHALL have parameter LV_BLANK, default 16, cycles lval low between lines (minimum 1).
REQ-008 SHALL have parameter FRAME_BLANK, default 32, cycles fval low between frames (minimum 1).
REQ-009 SHALL have one clock and asynchronous active-high reset: pix_clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-010 SHALL have the following ports, in addition to pix_clk and rst:
- enable, input, 1: frame generation enable.
- s_valid, input, 1: source pixel valid.
- s_data, input, DATA_WIDTH: source pixel.
- s_ready, output, 1: pixel accepted when s_valid && s_ready.
- fval, output, 1: frame valid.
- lval, output, 1: line valid.
- dval, output, 1: data valid.
- pix_data, output, DATA_WIDTH: output pixel.
- frame_done, output, 1: one-cycle pulse.
- frame_cnt, output, 16: completed frames.
- stall_cnt, output, 16: starved cycles.

Function
REQ-011 SHALL implement states IDLE, FSTART, LINE, LBLANK, FEND.
REQ-012 SHALL implement these transitions:
- IDLE->FSTART when enable=1.
- FSTART->LINE after FV_TO_LV cycles.
- LINE->LBLANK on the WIDTH-th handshake when lines remain.
- LINE->FEND on the WIDTH-th handshake of line HEIGHT.
- LBLANK->LINE after LV_BLANK cycles.
- FEND->FSTART after FRAME_BLANK cycles if enable=1, else FEND->IDLE.
REQ-013 SHALL drive s_ready combinationally as (state==LINE).
REQ-014 SHALL register all video outputs with 1-cycle latency from state decode:
- fval <= state in {FSTART, LINE, LBLANK}.
- lval <= (state==LINE).
- dval <= s_valid && s_ready.
- pix_data <= s_data on handshake, else holds its value.
REQ-015 SHALL advance the pixel counter only on handshake; s_valid=0 in LINE leaves lval=1, dval=0 (stall) and increments stall_cnt, which saturates at 16'hFFFF.
REQ-016 SHALL keep lval high through a stall; line length is counted in handshakes, never in cycles.
REQ-017 SHALL reset pixel counter to 0 and increment line counter at every line end, and reset both to 0 in FSTART.
REQ-018 SHALL drop fval and lval in the same cycle after the last pixel of a frame.
REQ-019 SHALL assert frame_done for one cycle, aligned with the last dval of a frame, and increment frame_cnt (wrapping at 16'hFFFF->0) on that same cycle.
REQ-020 SHALL not abort a frame when enable deasserts mid-frame; the frame completes and enable is sampled only in IDLE and at FEND exit.
REQ-021 SHALL ignore s_valid/s_data outside LINE; no data is consumed.
REQ-022 SHALL give fval-high length = FV_TO_LV + HEIGHT*WIDTH + (HEIGHT-1)*LV_BLANK + stall cycles.

Reset
REQ-023 SHALL, while rst=1, asynchronously force: state IDLE, counters 0, fval=lval=dval=0, pix_data=0, s_ready=0, frame_done=0, frame_cnt=0, stall_cnt=0.
REQ-024 SHALL, when rst asserts mid-frame, truncate the frame immediately without a frame_done pulse; after release, the next frame starts from line 0, pixel 0.

Verification
Scenarios use WIDTH=4, HEIGHT=2, FV_TO_LV=2, LV_BLANK=3, FRAME_BLANK=5.
REQ-025 SHALL cover: enable=1, s_valid=1 always -> fval high 13 cycles, low 5; lval two 4-cycle pulses 3 apart; 8 dval; frame_done once per frame.
REQ-026 SHALL cover: s_data=incrementing count 0..7 -> pix_data sequence 0..7 on dval, line 0 = 0..3, line 1 = 4..7.
REQ-027 SHALL cover: s_valid=0 for 2 cycles mid line 0 -> lval pulse 6 cycles, dval low 2 cycles, stall_cnt=2, fval high 15 cycles.
REQ-028 SHALL cover: enable dropped during line 0 -> frame completes, frame_cnt=1, fval stays 0, state IDLE.
REQ-029 SHALL cover: rst pulsed during line 1 -> all outputs 0 immediately, frame_cnt=0; next frame pix_data starts at the source's current value with line 0.
REQ-030 SHALL cover: back-to-back loopback into file_frame_grabber (WIDTH=640, HEIGHT=512) -> written image matches source ramp pattern.

Source files
------------

// File: rtl/camlink_frame_source.sv
// Camera Link style frame generator: paces a pixel stream into fval/lval/dval framing.
// Blanking intervals are timed with a shared down-counter; line length is counted in handshakes.
module camlink_frame_source #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 512,
  parameter int BPP         = 12,
  parameter int COLORED     = 0,
  parameter int DATA_WIDTH  = COLORED ? 24 : BPP,
  parameter int FV_TO_LV    = 4,
  parameter int LV_BLANK    = 16,
  parameter int FRAME_BLANK = 32
) (
  input  logic                  pix_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  fval,
  output logic                  lval,
  output logic                  dval,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           stall_cnt
);

  localparam int PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TM1  = (FV_TO_LV > LV_BLANK) ? FV_TO_LV : LV_BLANK;
  localparam int TMAX = (TM1 > FRAME_BLANK) ? TM1 : FRAME_BLANK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0] PIX_LAST  = PW'(WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);
  localparam logic [TW-1:0] T_FSTART  = TW'(FV_TO_LV - 1);
  localparam logic [TW-1:0] T_LBLANK  = TW'(LV_BLANK - 1);
  localparam logic [TW-1:0] T_FEND    = TW'(FRAME_BLANK - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FSTART = 3'd1;
  localparam logic [2:0] ST_LINE   = 3'd2;
  localparam logic [2:0] ST_LBLANK = 3'd3;
  localparam logic [2:0] ST_FEND   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [PW-1:0]         pix_q, pix_d;
  logic [LW-1:0]         line_q, line_d;
  logic                  fval_q, fval_d;
  logic                  lval_q, lval_d;
  logic                  dval_q, dval_d;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                  frame_done_q, frame_done_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic                  in_line, hs, last_pix, last_line;

  assign in_line   = (state_q == ST_LINE);
  assign hs        = in_line && s_valid;
  assign last_pix  = (pix_q == PIX_LAST);
  assign last_line = (line_q == LINE_LAST);

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    pix_d        = pix_q;
    line_d       = line_q;
    fval_d       = (state_q == ST_FSTART) || in_line || (state_q == ST_LBLANK);
    lval_d       = in_line;
    dval_d       = hs;
    pix_data_d   = hs ? s_data : pix_data_q;
    frame_done_d = hs && last_pix && last_line;
    frame_cnt_d  = frame_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
    if (in_line && !s_valid && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FSTART;
          tmr_d   = T_FSTART;
        end
      end
      ST_FSTART: begin
        pix_d  = '0;
        line_d = '0;
        if (tmr_q == '0) state_d = ST_LINE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_LINE: begin
        if (hs) begin
          if (last_pix) begin
            pix_d = '0;
            if (last_line) begin
              line_d  = '0;
              state_d = ST_FEND;
              tmr_d   = T_FEND;
            end else begin
              line_d  = line_q + 1'b1;
              state_d = ST_LBLANK;
              tmr_d   = T_LBLANK;
            end
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      ST_LBLANK: begin
        if (tmr_q == '0) state_d = ST_LINE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_FEND: begin
        // enable only matters here and in IDLE, so a dropped enable never cuts a frame short
        if (tmr_q == '0) begin
          if (enable) begin
            state_d = ST_FSTART;
            tmr_d   = T_FSTART;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      pix_q        <= '0;
      line_q       <= '0;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      dval_q       <= 1'b0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      fval_q       <= fval_d;
      lval_q       <= lval_d;
      dval_q       <= dval_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign s_ready    = in_line;
  assign fval       = fval_q;
  assign lval       = lval_q;
  assign dval       = dval_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
